codec_cfg_scheduler: RTL and testbench
======================================

CODEC_CFG_SCHEDULER -- requirements
Module: codec_cfg_scheduler

Interface
REQ-001 SHALL have parameter DEV_ADDR, default 8'h34, I2C device address byte (write, R/W=0).
REQ-002 SHALL have parameter RETRY_MAX, default 2, retries per frame after NACK.
REQ-003 SHALL have port i_clk  in  1  clock.
REQ-004 SHALL have port i_rst_n  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port i_start  in  1  one-cycle pulse; (re)start init table.
REQ-006 SHALL have port i_upd_valid  in  1  runtime register-write request.
REQ-007 SHALL have port i_upd_addr  in  7  codec register address.
REQ-008 SHALL have port i_upd_data  in  9  codec register data.
REQ-009 SHALL have port o_upd_ready  out  1  runtime request accepted when valid&ready.
REQ-010 SHALL have port o_tx_valid  out  1  frame offered to I2C word engine.
REQ-011 SHALL have port o_tx_word  out  24  {DEV_ADDR, addr[6:0], data[8:0]}.
REQ-012 SHALL have port i_tx_ready  in  1  engine accepts frame when valid&ready.
REQ-013 SHALL have port i_tx_done  in  1  one-cycle pulse; frame finished incl. STOP.
REQ-014 SHALL have port i_tx_nack  in  1  qualifies i_tx_done; frame NACKed.
REQ-015 SHALL have port o_init_done  out  1  init table fully ACKed.
REQ-016 SHALL have port o_busy  out  1  frame outstanding or init in progress.
REQ-017 SHALL have port o_err  out  1  sticky; frame failed after retries.

Function
REQ-018 SHALL implement states IDLE, INIT_ISSUE, INIT_WAIT, RUN, UPD_ISSUE, UPD_WAIT, ERROR.
REQ-019 SHALL issue init table in order: (0x0F,0x000),(0x04,0x015),(0x05,0x000),(0x06,0x000),(0x07,0x042),(0x08,0x019),(0x09,0x001); 7 entries.
REQ-020 SHALL in IDLE move to INIT_ISSUE on i_start, index=0, retry count=0, o_err cleared.
REQ-021 SHALL in *_ISSUE hold o_tx_valid=1 and o_tx_word stable until i_tx_ready, then enter *_WAIT with o_tx_valid=0 next cycle.
REQ-022 SHALL in INIT_WAIT on i_tx_done&!i_tx_nack: last index -> RUN with o_init_done=1 next cycle; else index+1, retry=0, INIT_ISSUE.
REQ-023 SHALL on i_tx_done&i_tx_nack reissue same word if retry<RETRY_MAX (retry+1); else enter ERROR, o_err=1.
REQ-024 SHALL keep o_upd_ready=1 only in RUN; request captured into holding register on valid&ready, then UPD_ISSUE.
REQ-025 SHALL in UPD_WAIT apply REQ-023 retry rule; success returns to RUN.
REQ-026 SHALL give i_start priority over i_upd_valid in the same RUN cycle (o_upd_ready=0 that cycle); restart clears o_init_done.
REQ-027 SHALL ignore i_start while a frame is outstanding (ISSUE/WAIT states).
REQ-028 SHALL in ERROR drive o_tx_valid=0, o_upd_ready=0; leave only on i_start (to INIT_ISSUE, o_err cleared).
REQ-029 SHALL ignore i_tx_done outside *_WAIT.
REQ-030 SHALL drive o_busy=1 in all states except IDLE, RUN, ERROR.

Reset
REQ-031 SHALL on reset: state=IDLE, o_tx_valid=0, o_tx_word=0, o_upd_ready=0, o_init_done=0, o_busy=0, o_err=0, index=0, retry=0.
REQ-032 SHALL abandon any outstanding frame on reset mid-operation; no replay after release.

Configuration
REQ-033 SHALL honour macro CODEC_CFG_RETRY_EN: defined -> retries per REQ-023; undefined -> first NACK enters ERROR, RETRY_MAX unused.

Structure
REQ-034 SHALL place init table, entry count, 24-bit word typedef and state enum in package codec_cfg_pkg.
REQ-035 SHALL use one sub-module codec_cfg_rom: index in, {addr,data} out, combinational.

Verification
REQ-036 SHALL check: i_start, engine always ACKs -> 7 words 0x341E00,0x340815,0x340A00,0x340C00,0x340E42,0x341019,0x341201 in order, then o_init_done=1.
REQ-037 SHALL check: NACK on entry 3 once -> word 0x340C00 reissued, init completes, o_err=0.
REQ-038 SHALL check: NACK on entry 0 three times (RETRY_MAX=2) -> ERROR, o_err=1, o_tx_valid=0; with macro undefined, first NACK -> ERROR.
REQ-039 SHALL check: RUN, upd addr=0x02 data=0x079 -> o_tx_word=0x340479, return to RUN, o_upd_ready=1.
REQ-040 SHALL check: i_start and i_upd_valid same RUN cycle -> update not accepted, first word 0x341E00.
REQ-041 SHALL check: reset asserted in INIT_WAIT -> all outputs at REQ-031 values; no frame until next i_start.

Source files
------------

// File: rtl/codec_cfg_pkg.sv
// rtl/codec_cfg_pkg.sv - shared types, state encoding and init table for the codec config scheduler
package codec_cfg_pkg;

    localparam int INIT_ENTRIES = 7;
    localparam int IDX_W        = 3;

    typedef logic [23:0] cfg_word_t;
    typedef logic [15:0] cfg_entry_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT_ISSUE,
        ST_INIT_WAIT,
        ST_RUN,
        ST_UPD_ISSUE,
        ST_UPD_WAIT,
        ST_ERROR
    } state_t;

    // Each entry is {reg_addr[6:0], reg_data[8:0]}
    localparam cfg_entry_t INIT_TABLE [INIT_ENTRIES] = '{
        {7'h0F, 9'h000},
        {7'h04, 9'h015},
        {7'h05, 9'h000},
        {7'h06, 9'h000},
        {7'h07, 9'h042},
        {7'h08, 9'h019},
        {7'h09, 9'h001}
    };

    function automatic cfg_word_t mk_word(input logic [7:0] dev, input cfg_entry_t entry);
        return {dev, entry};
    endfunction

endpackage

// File: rtl/codec_cfg_rom.sv
// rtl/codec_cfg_rom.sv - combinational lookup of the codec init table
module codec_cfg_rom
    import codec_cfg_pkg::*;
(
    input  logic [IDX_W-1:0] idx_i,
    output cfg_entry_t       entry_o
);

    always_comb begin
        entry_o = '0;
        if (idx_i < IDX_W'(INIT_ENTRIES)) begin
            entry_o = INIT_TABLE[idx_i];
        end
    end

endmodule

// File: rtl/codec_cfg_scheduler.sv
// rtl/codec_cfg_scheduler.sv - issues codec init table and runtime register writes as I2C frames
// Optional feature: define CODEC_CFG_RETRY_EN to retry NACKed frames up to RETRY_MAX times.
module codec_cfg_scheduler
    import codec_cfg_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR  = 8'h34,
    parameter int          RETRY_MAX = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_upd_valid,
    input  logic [6:0]  i_upd_addr,
    input  logic [8:0]  i_upd_data,
    output logic        o_upd_ready,
    output logic        o_tx_valid,
    output logic [23:0] o_tx_word,
    input  logic        i_tx_ready,
    input  logic        i_tx_done,
    input  logic        i_tx_nack,
    output logic        o_init_done,
    output logic        o_busy,
    output logic        o_err
);

`ifdef CODEC_CFG_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif
    localparam int RETRY_LIMIT = RETRY_EN ? RETRY_MAX : 0;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       retry_q, retry_d;
    cfg_entry_t       upd_q, upd_d;
    logic             init_done_q, init_done_d;
    logic             err_q, err_d;
    cfg_entry_t       rom_entry;

    codec_cfg_rom u_rom (
        .idx_i   (idx_q),
        .entry_o (rom_entry)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            retry_q     <= '0;
            upd_q       <= '0;
            init_done_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            upd_q       <= upd_d;
            init_done_q <= init_done_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        upd_d       = upd_q;
        init_done_d = init_done_q;
        err_d       = err_q;
        case (state_q)
            ST_IDLE, ST_ERROR, ST_RUN: begin
                if (i_start) begin
                    state_d     = ST_INIT_ISSUE;
                    idx_d       = '0;
                    retry_d     = '0;
                    err_d       = 1'b0;
                    init_done_d = 1'b0;
                end else if (state_q == ST_RUN && i_upd_valid) begin
                    state_d = ST_UPD_ISSUE;
                    upd_d   = {i_upd_addr, i_upd_data};
                    retry_d = '0;
                end
            end
            ST_INIT_ISSUE: if (i_tx_ready) state_d = ST_INIT_WAIT;
            ST_UPD_ISSUE:  if (i_tx_ready) state_d = ST_UPD_WAIT;
            ST_INIT_WAIT, ST_UPD_WAIT: begin
                if (i_tx_done && i_tx_nack) begin
                    // Retry the same frame while budget remains; the ROM index / holding register are unchanged
                    if (retry_q < 8'(RETRY_LIMIT)) begin
                        retry_d = retry_q + 8'd1;
                        state_d = (state_q == ST_INIT_WAIT) ? ST_INIT_ISSUE : ST_UPD_ISSUE;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                    end
                end else if (i_tx_done) begin
                    retry_d = '0;
                    if (state_q == ST_UPD_WAIT) begin
                        state_d = ST_RUN;
                    end else if (idx_q == IDX_W'(INIT_ENTRIES - 1)) begin
                        state_d     = ST_RUN;
                        init_done_d = 1'b1;
                    end else begin
                        state_d = ST_INIT_ISSUE;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_tx_valid  = 1'b0;
        o_tx_word   = '0;
        o_upd_ready = 1'b0;
        o_busy      = 1'b0;
        case (state_q)
            ST_INIT_ISSUE: begin
                o_tx_valid = 1'b1;
                o_tx_word  = mk_word(DEV_ADDR, rom_entry);
                o_busy     = 1'b1;
            end
            ST_UPD_ISSUE: begin
                o_tx_valid = 1'b1;
                o_tx_word  = mk_word(DEV_ADDR, upd_q);
                o_busy     = 1'b1;
            end
            ST_INIT_WAIT, ST_UPD_WAIT: o_busy = 1'b1;
            // A simultaneous restart wins, so the update is not acknowledged
            ST_RUN: o_upd_ready = !i_start;
            default: ;
        endcase
    end

    assign o_init_done = init_done_q;
    assign o_err       = err_q;

endmodule

// File: tb/tb_codec_cfg_scheduler.sv
// tb/tb_codec_cfg_scheduler.sv - scoreboard bench for codec_cfg_scheduler
module tb_codec_cfg_scheduler;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_upd_valid = 1'b0;
    logic [6:0]  i_upd_addr = '0;
    logic [8:0]  i_upd_data = '0;
    logic        o_upd_ready;
    logic        o_tx_valid;
    logic [23:0] o_tx_word;
    logic        i_tx_ready = 1'b0;
    logic        i_tx_done = 1'b0;
    logic        i_tx_nack = 1'b0;
    logic        o_init_done;
    logic        o_busy;
    logic        o_err;

    int          tests = 0;
    int          fails = 0;
    int          frames = 0;
    logic [23:0] exp_q[$];
    bit          nack_plan[$];
    logic [23:0] init_words [7] = '{24'h341E00, 24'h340815, 24'h340A00, 24'h340C00,
                                    24'h340E42, 24'h341019, 24'h341201};
    logic [23:0] mon_exp;
    bit          eng_pend = 1'b0;
    int          eng_wait = 0;
    int          snap;

    always #5 i_clk = ~i_clk;

    codec_cfg_scheduler #(.DEV_ADDR(8'h34), .RETRY_MAX(2)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_start     (i_start),
        .i_upd_valid (i_upd_valid),
        .i_upd_addr  (i_upd_addr),
        .i_upd_data  (i_upd_data),
        .o_upd_ready (o_upd_ready),
        .o_tx_valid  (o_tx_valid),
        .o_tx_word   (o_tx_word),
        .i_tx_ready  (i_tx_ready),
        .i_tx_done   (i_tx_done),
        .i_tx_nack   (i_tx_nack),
        .o_init_done (o_init_done),
        .o_busy      (o_busy),
        .o_err       (o_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every accepted frame is matched against the scoreboard
    always @(negedge i_clk) begin
        if (i_rst_n && o_tx_valid && i_tx_ready) begin
            frames++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame: got 0x%0h, expected none", o_tx_word);
            end else begin
                mon_exp = exp_q.pop_front();
                check("tx_word", {8'h0, o_tx_word}, {8'h0, mon_exp});
            end
        end
    end

    // Engine model: accept, then report done (with planned NACK) three cycles later
    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            i_tx_done = 1'b0;
            i_tx_nack = 1'b0;
            if (!i_rst_n) begin
                i_tx_ready = 1'b0;
                eng_pend   = 1'b0;
            end else if (i_tx_ready) begin
                i_tx_ready = 1'b0;
                eng_pend   = 1'b1;
                eng_wait   = 2;
            end else if (eng_pend) begin
                if (eng_wait == 0) begin
                    i_tx_done = 1'b1;
                    i_tx_nack = (nack_plan.size() != 0) ? nack_plan.pop_front() : 1'b0;
                    eng_pend  = 1'b0;
                end else begin
                    eng_wait--;
                end
            end else if (o_tx_valid) begin
                i_tx_ready = 1'b1;
            end
        end
    end

    task automatic pulse_start();
        @(posedge i_clk); #1 i_start = 1'b1;
        @(posedge i_clk); #1 i_start = 1'b0;
    endtask

    task automatic push_init();
        for (int i = 0; i < 7; i++) exp_q.push_back(init_words[i]);
    endtask

    task automatic wait_until(input int sel, input int limit, input string name);
        bit hit;
        hit = 1'b0;
        for (int c = 0; c < limit && !hit; c++) begin
            @(negedge i_clk);
            case (sel)
                0: hit = o_init_done;
                1: hit = o_err;
                2: hit = o_upd_ready;
                default: hit = (exp_q.size() == 0) && o_busy && !o_tx_valid;
            endcase
        end
        if (!hit) begin
            tests++;
            fails++;
            $display("FAIL timeout_%s: got no event, expected event within %0d cycles", name, limit);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, {31'h0, o_tx_valid}, 0);
        check({tag, "_tx_word"}, {8'h0, o_tx_word}, 0);
        check({tag, "_upd_ready"}, {31'h0, o_upd_ready}, 0);
        check({tag, "_init_done"}, {31'h0, o_init_done}, 0);
        check({tag, "_busy"}, {31'h0, o_busy}, 0);
        check({tag, "_err"}, {31'h0, o_err}, 0);
    endtask

    initial begin
        repeat (3) @(negedge i_clk);
        check_reset_outputs("rst");
        @(posedge i_clk); #1 i_rst_n = 1'b1;

        // Full init, engine always ACKs
        push_init();
        pulse_start();
        wait_until(0, 400, "init");
        check("init_done", {31'h0, o_init_done}, 1);
        check("init_busy", {31'h0, o_busy}, 0);
        check("init_upd_ready", {31'h0, o_upd_ready}, 1);
        check("init_q_empty", exp_q.size(), 0);

        // Runtime update addr 0x02 data 0x079
        exp_q.push_back(24'h340479);
        @(posedge i_clk); #1;
        i_upd_valid = 1'b1; i_upd_addr = 7'h02; i_upd_data = 9'h079;
        @(posedge i_clk); #1 i_upd_valid = 1'b0;
        wait_until(2, 100, "upd");
        check("upd_ready", {31'h0, o_upd_ready}, 1);
        check("upd_busy", {31'h0, o_busy}, 0);
        check("upd_q_empty", exp_q.size(), 0);

        // Start and update in the same RUN cycle: start wins
        push_init();
        @(posedge i_clk); #1;
        i_start = 1'b1; i_upd_valid = 1'b1; i_upd_addr = 7'h11; i_upd_data = 9'h1AA;
        @(negedge i_clk);
        check("prio_upd_ready", {31'h0, o_upd_ready}, 0);
        @(posedge i_clk); #1 i_start = 1'b0; i_upd_valid = 1'b0;
        @(negedge i_clk);
        check("prio_init_cleared", {31'h0, o_init_done}, 0);
        wait_until(0, 400, "prio_init");
        check("prio_q_empty", exp_q.size(), 0);

        // NACK on entry 3 once
        nack_plan = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) exp_q.push_back(init_words[i]);
`ifdef CODEC_CFG_RETRY_EN
        for (int i = 3; i < 7; i++) exp_q.push_back(init_words[i]);
        pulse_start();
        wait_until(0, 400, "nack3_init");
        check("nack3_err", {31'h0, o_err}, 0);
        check("nack3_init_done", {31'h0, o_init_done}, 1);
`else
        pulse_start();
        wait_until(1, 400, "nack3_err");
        check("nack3_err", {31'h0, o_err}, 1);
        check("nack3_init_done", {31'h0, o_init_done}, 0);
`endif
        check("nack3_q_empty", exp_q.size(), 0);

        // Persistent NACK on entry 0
`ifdef CODEC_CFG_RETRY_EN
        nack_plan = '{1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) exp_q.push_back(init_words[0]);
`else
        nack_plan = '{1'b1};
        exp_q.push_back(init_words[0]);
`endif
        pulse_start();
        wait_until(1, 400, "nack0_err");
        repeat (3) @(negedge i_clk);
        check("nack0_err", {31'h0, o_err}, 1);
        check("nack0_tx_valid", {31'h0, o_tx_valid}, 0);
        check("nack0_upd_ready", {31'h0, o_upd_ready}, 0);
        check("nack0_busy", {31'h0, o_busy}, 0);
        check("nack0_q_empty", exp_q.size(), 0);
        check("nack0_plan_empty", nack_plan.size(), 0);

        // Reset while the first frame is outstanding
        exp_q.push_back(init_words[0]);
        pulse_start();
        wait_until(3, 50, "init_wait");
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        snap = frames;
        repeat (3) @(negedge i_clk);
        @(posedge i_clk); #1 i_rst_n = 1'b1;
        repeat (20) @(negedge i_clk);
        check("midrst_no_frame", frames - snap, 0);
        check("midrst_idle_valid", {31'h0, o_tx_valid}, 0);
        check("midrst_idle_busy", {31'h0, o_busy}, 0);

        // Recovery after reset
        push_init();
        pulse_start();
        wait_until(0, 400, "recover");
        check("recover_init_done", {31'h0, o_init_done}, 1);
        check("recover_q_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
